// File: rtl/parity_frame_checker.sv
// parity_frame_checker
//
// Accumulates parity over a frame of WIDTH-bit words and reports one result
// per frame. The result holds the generated parity bit (even or odd mode), a
// mismatch flag against a received parity bit, an overflow flag, and the word
// count.
//
// Handshake: a word transfers on a rising edge where in_valid & in_ready.
// A result transfers on a rising edge where out_valid & out_ready.
// in_ready does not depend on in_valid, and out_valid does not depend on
// out_ready. A producer that raises valid keeps it and its payload stable
// until the transfer completes.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active high, dominant
//   odd_sel    0 = even, 1 = odd parity; latched on the first word of a frame
//   in_valid   input word valid
//   in_ready   block can accept a word (IDLE/ACCUM)
//   in_data    WIDTH-bit data word
//   in_last    last word of the frame
//   chk_bit    received parity bit, sampled with the in_last word
//   out_valid  frame result valid (DONE)
//   out_ready  consumer accepts the result
//   out_parity generated parity bit for the frame
//   out_error  received parity mismatch
//   out_ovf    frame force-closed at MAX_WORDS without in_last
//   out_count  words accepted in the frame
module parity_frame_checker #(
    parameter int WIDTH     = 4,
    parameter int MAX_WORDS = 16,
    localparam int CW       = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             odd_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             chk_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             out_error,
    output logic             out_ovf,
    output logic [CW-1:0]    out_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

    state_t          state_q, state_d;
    logic            acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic            par_q, par_d;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   count_q, count_d;

    // Running values as they would be after accepting the current word.
    // In IDLE the word opens a new frame, so the accumulator and counter
    // restart and the mode is taken from odd_sel.
    logic            word_par;
    logic            acc_nx;
    logic [CW-1:0]   cnt_nx;
    logic            mode_nx;

    always_comb begin
        word_par = ^in_data;
        acc_nx   = acc_q ^ word_par;
        cnt_nx   = cnt_q + CW'(1);
        mode_nx  = mode_q;
        if (state_q == IDLE) begin
            acc_nx  = word_par;
            cnt_nx  = CW'(1);
            mode_nx = odd_sel;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        par_d   = par_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        unique case (state_q)
            IDLE, ACCUM: begin
                if (in_valid) begin
                    acc_d  = acc_nx;
                    cnt_d  = cnt_nx;
                    mode_d = mode_nx;
                    // in_last wins over overflow when both coincide, so a
                    // properly terminated MAX_WORDS frame is a normal close.
                    if (in_last || (cnt_nx == MAX_CNT)) begin
                        state_d = DONE;
                        par_d   = acc_nx ^ mode_nx;
                        count_d = cnt_nx;
                        if (in_last) begin
                            err_d = acc_nx ^ chk_bit ^ mode_nx;
                            ovf_d = 1'b0;
                        end else begin
                            err_d = 1'b0;
                            ovf_d = 1'b1;
                        end
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            DONE: begin
                // No bypass: in_ready is low here, so no word can enter in
                // the cycle the result leaves.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            par_q   <= par_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    assign in_ready   = (state_q != DONE);
    assign out_valid  = (state_q == DONE);
    assign out_parity = par_q;
    assign out_error  = err_q;
    assign out_ovf    = ovf_q;
    assign out_count  = count_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
module tb_parity_frame_checker;

    localparam int WIDTH     = 4;
    localparam int MAX_WORDS = 4;
    localparam int CW        = $clog2(MAX_WORDS + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             odd_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             chk_bit;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic             out_error;
    logic             out_ovf;
    logic [CW-1:0]    out_count;

    int checks = 0;
    int errors = 0;

    parity_frame_checker #(
        .WIDTH    (WIDTH),
        .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .odd_sel   (odd_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .chk_bit   (chk_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_parity(out_parity),
        .out_error (out_error),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: present one word for exactly one edge; in_ready must be high.
    task automatic send_word(input string tag, input logic [WIDTH-1:0] data, input logic last,
                             input logic chk, input logic odd);
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        chk_bit  = chk;
        odd_sel  = odd;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_taken_valid"}, out_valid, 0);
        check({tag, "_taken_ready"}, in_ready, 1);
    endtask

    task automatic check_result(input string tag, input logic par, input logic err,
                                input logic ovf, input logic [CW-1:0] cnt);
        check({tag, "_valid"},  out_valid, 1);
        check({tag, "_ready"},  in_ready, 0);
        check({tag, "_parity"}, out_parity, par);
        check({tag, "_error"},  out_error, err);
        check({tag, "_ovf"},    out_ovf, ovf);
        check({tag, "_count"},  out_count, cnt);
    endtask

    initial begin
        rst       = 1'b1;
        odd_sel   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        chk_bit   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready",  in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_parity",    out_parity, 0);
        check("rst_error",     out_error, 0);
        check("rst_ovf",       out_ovf, 0);
        check("rst_count",     out_count, 0);

        // 1: even, single word 1011 (three ones), chk=1 -> parity 1, no error
        send_word("t1", 4'b1011, 1'b1, 1'b1, 1'b0);
        check_result("t1", 1'b1, 1'b0, 1'b0, 3'd1);
        take_result("t1");
        check("t1_hold_parity", out_parity, 1);
        check("t1_hold_count",  out_count, 1);

        // 2: odd, F,1,6 -> acc=1, parity 0, chk=0 -> no error, count 3
        send_word("t2_w0", 4'hF, 1'b0, 1'b0, 1'b1);
        send_word("t2_w1", 4'h1, 1'b0, 1'b0, 1'b1);
        check("t2_mid_valid", out_valid, 0);
        send_word("t2_w2", 4'h6, 1'b1, 1'b0, 1'b1);
        check_result("t2", 1'b0, 1'b0, 1'b0, 3'd2 + 3'd1);
        take_result("t2");

        // 3: backpressure; 7 even -> parity 1, chk=0 -> error 1.
        // in_valid held high while DONE must not be accepted.
        send_word("t3", 4'h7, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 4'h1;
        for (int i = 0; i < 5; i++) begin
            check_result("t3_hold", 1'b1, 1'b1, 1'b0, 3'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("t3_taken_valid", out_valid, 0);
        check("t3_taken_ready", in_ready, 1);
        check("t3_after_count", out_count, 1);
        check("t3_after_error", out_error, 1);
        tick();
        check("t3_idle_valid", out_valid, 0);

        // 4: overflow at MAX_WORDS=4, odd mode; pars 1,0,1,0 -> acc 0,
        // parity 1; chk ignored so error stays 0 despite chk=0.
        send_word("t4_w0", 4'h1, 1'b0, 1'b0, 1'b1);
        send_word("t4_w1", 4'h3, 1'b0, 1'b0, 1'b1);
        send_word("t4_w2", 4'h7, 1'b0, 1'b0, 1'b1);
        check("t4_mid_valid", out_valid, 0);
        send_word("t4_w3", 4'hF, 1'b0, 1'b0, 1'b1);
        check_result("t4", 1'b1, 1'b0, 1'b1, 3'd4);
        tick();
        check("t4_still_blocked", in_ready, 0);
        take_result("t4");

        // 5: reset mid-frame discards the partial frame
        send_word("t5_w0", 4'h1, 1'b0, 1'b0, 1'b0);
        send_word("t5_w1", 4'h2, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_in_ready",  in_ready, 1);
        check("t5_rst_out_valid", out_valid, 0);
        check("t5_rst_parity",    out_parity, 0);
        check("t5_rst_error",     out_error, 0);
        check("t5_rst_ovf",       out_ovf, 0);
        check("t5_rst_count",     out_count, 0);
        send_word("t5_w2", 4'h3, 1'b1, 1'b0, 1'b0);
        check_result("t5", 1'b0, 1'b0, 1'b0, 3'd1);
        take_result("t5");

        // 6: mode latched on first word (even); odd_sel toggles before last.
        // 3 (par 0) then 1 (par 1) -> acc 1, even parity 1, chk=1 -> no error.
        send_word("t6_w0", 4'h3, 1'b0, 1'b0, 1'b0);
        send_word("t6_w1", 4'h1, 1'b1, 1'b1, 1'b1);
        check_result("t6", 1'b1, 1'b0, 1'b0, 3'd2);
        take_result("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
